// File: rtl/mux_scan_pkg.sv
// Shared types and sizes for the mux scan sequencer.
// Optional feature macro: MUX_SCAN_PARITY_EN (adds the parity output).
package mux_scan_pkg;
   localparam int SEL_W   = 5;
   localparam int N       = 1 << SEL_W;
   localparam int COUNT_W = SEL_W + 1;

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_SCAN = 2'd1,
      ST_DONE = 2'd2
   } state_t;

   // A requested count of 0 means a full sweep of all N indices.
   function automatic logic [COUNT_W-1:0] norm_count(input logic [COUNT_W-1:0] c);
      return (c == '0) ? COUNT_W'(N) : c;
   endfunction
endpackage

// File: rtl/mux_scan_capture.sv
// Capture registers: rebuilds the scanned word bit-by-bit at the mux index positions.
// With MUX_SCAN_PARITY_EN defined, also accumulates the XOR of every captured bit.
module mux_scan_capture
   import mux_scan_pkg::*;
(
   input  logic             clk,
   input  logic             rst_n,
   input  logic             clr,
   input  logic             we,
   input  logic [SEL_W-1:0] idx,
   input  logic             y,
`ifdef MUX_SCAN_PARITY_EN
   output logic             parity,
`endif
   output logic [N-1:0]     word,
   output logic [N-1:0]     mask
);
   logic [N-1:0] r_word;
   logic [N-1:0] r_mask;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_word <= '0;
         r_mask <= '0;
      end else if (clr) begin
         r_word <= '0;
         r_mask <= '0;
      end else if (we) begin
         r_word[idx] <= y;
         r_mask[idx] <= 1'b1;
      end
   end

`ifdef MUX_SCAN_PARITY_EN
   logic r_parity;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n)   r_parity <= 1'b0;
      else if (clr) r_parity <= 1'b0;
      else if (we)  r_parity <= r_parity ^ y;
   end

   assign parity = r_parity;
`endif

   assign word = r_word;
   assign mask = r_mask;
endmodule

// File: rtl/mux_scan_ctrl.sv
// Scan sequencer around a 32:1 mux: walks sel through a run of indices and captures y.
// Optional feature macro: MUX_SCAN_PARITY_EN (adds the parity output).
module mux_scan_ctrl
   import mux_scan_pkg::*;
(
   input  logic               clk,
   input  logic               rst_n,
   input  logic               start,
   input  logic [SEL_W-1:0]   first,
   input  logic [COUNT_W-1:0] count,
   input  logic               y,
   output logic [SEL_W-1:0]   sel,
   output logic               busy,
   output logic               done,
`ifdef MUX_SCAN_PARITY_EN
   output logic               parity,
`endif
   output logic [N-1:0]       word,
   output logic [N-1:0]       mask
);
   state_t             r_state, w_nxt;
   logic [SEL_W-1:0]   r_sel;
   logic [COUNT_W-1:0] r_rem;
   logic               r_busy, r_done;
   logic               w_accept, w_we, w_busy_d, w_done_d;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) r_state <= ST_IDLE;
      else        r_state <= w_nxt;
   end

   always_comb begin
      w_nxt = r_state;
      case (r_state)
         ST_IDLE: if (start) w_nxt = ST_SCAN;
         ST_SCAN: if (r_rem == COUNT_W'(1)) w_nxt = ST_DONE;
         ST_DONE: w_nxt = ST_IDLE;
         default: w_nxt = ST_IDLE;
      endcase
   end

   always_comb begin
      w_accept = (r_state == ST_IDLE) && start;
      w_we     = (r_state == ST_SCAN);
      w_busy_d = (w_nxt == ST_SCAN) || (w_nxt == ST_DONE);
      w_done_d = (w_nxt == ST_DONE);
   end

   // On the final sample sel stays put so it reports the last index scanned.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_sel  <= '0;
         r_rem  <= '0;
         r_busy <= 1'b0;
         r_done <= 1'b0;
      end else begin
         r_busy <= w_busy_d;
         r_done <= w_done_d;
         if (w_accept) begin
            r_sel <= first;
            r_rem <= norm_count(count);
         end else if (w_we) begin
            r_rem <= r_rem - COUNT_W'(1);
            if (r_rem != COUNT_W'(1)) r_sel <= r_sel + SEL_W'(1);
         end
      end
   end

   mux_scan_capture u_capture (
      .clk    (clk),
      .rst_n  (rst_n),
      .clr    (w_accept),
      .we     (w_we),
      .idx    (r_sel),
      .y      (y),
`ifdef MUX_SCAN_PARITY_EN
      .parity (parity),
`endif
      .word   (word),
      .mask   (mask)
   );

   assign sel  = r_sel;
   assign busy = r_busy;
   assign done = r_done;
endmodule

// File: tb/tb_mux_scan_ctrl.sv
// Self-checking bench for mux_scan_ctrl; models the mux and predicts each run from its index set.
module tb_mux_scan_ctrl;
   logic        clk = 1'b0;
   logic        rst_n = 1'b0;
   logic        start = 1'b0;
   logic [4:0]  first = '0;
   logic [5:0]  count = '0;
   logic        y;
   logic [4:0]  sel;
   logic        busy, done;
   logic [31:0] word, mask;
   logic [31:0] mux_in = '0;
`ifdef MUX_SCAN_PARITY_EN
   logic        parity;
`endif
   int n_cmp = 0;
   int n_bad = 0;

   always #5 clk = ~clk;
   assign y = mux_in[sel];

   mux_scan_ctrl dut (
      .clk(clk), .rst_n(rst_n), .start(start), .first(first), .count(count), .y(y),
      .sel(sel), .busy(busy), .done(done),
`ifdef MUX_SCAN_PARITY_EN
      .parity(parity),
`endif
      .word(word), .mask(mask)
   );

   task automatic test_reset();
      rst_n = 1'b0;
      repeat (2) @(posedge clk);
      #1;
      n_cmp++;
      if ({sel, busy, done, word, mask} !== '0) begin
         n_bad++;
         $display("FAIL reset_state: sel=%0d busy=%b done=%b word=%h mask=%h, want all 0", sel, busy, done, word, mask);
      end
      @(negedge clk); rst_n = 1'b1;
   endtask

   // One run: expectations come from the set of indices {first+j mod 32 : j < n}.
   task automatic do_scan(input logic [31:0] I, input int f, input int c, input string nm, input bit disturb);
      int n, cycles;
      bit seq_ok, busy_ok;
      logic [31:0] ew, em;
      logic [4:0] es;
      n = (c == 0) ? 32 : c;
      ew = '0; em = '0;
      for (int j = 0; j < n; j++) begin
         em[(f + j) % 32] = 1'b1;
         ew[(f + j) % 32] = I[(f + j) % 32];
      end
      mux_in = I;
      @(negedge clk);
      start = 1'b1; first = 5'(f); count = 6'(c);
      @(posedge clk); #1;
      start = 1'b0;
      n_cmp++;
      if (sel !== 5'(f) || busy !== 1'b1 || done !== 1'b0) begin
         n_bad++;
         $display("FAIL %s_accept: sel=%0d busy=%b done=%b, want sel=%0d busy=1 done=0", nm, sel, busy, done, f);
      end
      cycles = 0; seq_ok = 1; busy_ok = 1;
      while (!done && cycles < 100) begin
         es = 5'((f + cycles) % 32);
         if (cycles < n && sel !== es) seq_ok = 0;
         if (busy !== 1'b1) busy_ok = 0;
         if (disturb && cycles == 3) begin
            start = 1'b1; first = 5'(f + 7); count = 6'd1;
         end else start = 1'b0;
         @(posedge clk); #1;
         cycles++;
      end
      start = 1'b0;
      n_cmp++;
      if (cycles !== n) begin
         n_bad++;
         $display("FAIL %s_latency: done after %0d edges, want %0d", nm, cycles, n);
      end
      n_cmp++;
      if (!seq_ok || !busy_ok || busy !== 1'b1) begin
         n_bad++;
         $display("FAIL %s_sequence: sel_seq_ok=%b busy_ok=%b busy_at_done=%b, want 1 1 1", nm, seq_ok, busy_ok, busy);
      end
      es = 5'((f + n - 1) % 32);
      n_cmp++;
      if (word !== ew || mask !== em || sel !== es) begin
         n_bad++;
         $display("FAIL %s_result: word=%h mask=%h sel=%0d, want word=%h mask=%h sel=%0d", nm, word, mask, sel, ew, em, es);
      end
`ifdef MUX_SCAN_PARITY_EN
      n_cmp++;
      if (parity !== ^ew) begin
         n_bad++;
         $display("FAIL %s_parity: parity=%b, want %b", nm, parity, ^ew);
      end
`endif
      @(posedge clk); #1;
      n_cmp++;
      if (done !== 1'b0 || busy !== 1'b0 || word !== ew || mask !== em || sel !== es) begin
         n_bad++;
         $display("FAIL %s_hold: done=%b busy=%b word=%h mask=%h sel=%0d, want 0 0 %h %h %0d",
                  nm, done, busy, word, mask, sel, ew, em, es);
      end
   endtask

   task automatic test_plan_vectors();
      do_scan(32'd640, 0, 32, "full640", 0);
      do_scan(32'd640, 30, 12, "wrap12", 0);
      do_scan($urandom, 5, 0, "count0", 0);
      do_scan(32'd641, 0, 32, "full641", 0);
      do_scan(32'hFFFF_FFFF, 17, 1, "single", 0);
   endtask

   task automatic test_start_ignored();
      logic [31:0] I;
      I = $urandom;
      do_scan(I, 9, 20, "midstart", 1);
   endtask

   task automatic test_random();
      for (int t = 0; t < 12; t++)
         do_scan($urandom, int'($urandom_range(0, 31)), int'($urandom_range(0, 32)), "rand", 0);
   endtask

   // Start asserted during the done cycle must wait for IDLE.
   task automatic test_back_to_back();
      do_scan(32'h1234_5678, 3, 4, "b2b_a", 0);
      // do_scan leaves us one edge past done (IDLE); replay so done is live when start rises.
      mux_in = 32'hA5A5_0F0F;
      @(negedge clk); start = 1'b1; first = 5'd20; count = 6'd2;
      @(posedge clk); #1;
      first = 5'd11; count = 6'd3;
      repeat (2) @(posedge clk);
      #1;
      n_cmp++;
      if (done !== 1'b1 || sel !== 5'd21) begin
         n_bad++;
         $display("FAIL b2b_done: done=%b sel=%0d, want done=1 sel=21", done, sel);
      end
      @(posedge clk); #1;
      n_cmp++;
      if (busy !== 1'b0 || done !== 1'b0 || sel !== 5'd21) begin
         n_bad++;
         $display("FAIL b2b_ignored: busy=%b done=%b sel=%0d, want busy=0 done=0 sel=21", busy, done, sel);
      end
      @(posedge clk); #1;
      start = 1'b0;
      n_cmp++;
      if (busy !== 1'b1 || sel !== 5'd11 || mask !== 32'h0) begin
         n_bad++;
         $display("FAIL b2b_accept: busy=%b sel=%0d mask=%h, want busy=1 sel=11 mask=0", busy, sel, mask);
      end
      repeat (4) @(posedge clk);
      #1;
      n_cmp++;
      if (mask !== 32'h0000_3800 || word !== (32'hA5A5_0F0F & 32'h0000_3800)) begin
         n_bad++;
         $display("FAIL b2b_second: word=%h mask=%h, want word=%h mask=00003800",
                  word, mask, 32'hA5A5_0F0F & 32'h0000_3800);
      end
   endtask

   task automatic test_midscan_reset();
      bit saw_done;
      saw_done = 0;
      mux_in = 32'hDEAD_BEEF;
      @(negedge clk); start = 1'b1; first = 5'd0; count = 6'd32;
      @(posedge clk); #1; start = 1'b0;
      repeat (10) @(posedge clk);
      #1;
      rst_n = 1'b0;
      #1;
      n_cmp++;
      if ({sel, busy, done, word, mask} !== '0) begin
         n_bad++;
         $display("FAIL midreset_clear: sel=%0d busy=%b done=%b word=%h mask=%h, want all 0", sel, busy, done, word, mask);
      end
      @(negedge clk); rst_n = 1'b1;
      for (int i = 0; i < 40; i++) begin
         @(posedge clk); #1;
         if (done || busy) saw_done = 1;
      end
      n_cmp++;
      if (saw_done) begin
         n_bad++;
         $display("FAIL midreset_quiet: done/busy seen after reset, want none");
      end
      do_scan(32'd640, 0, 32, "after_reset", 0);
   endtask

   initial begin
      test_reset();
      test_plan_vectors();
      test_start_ignored();
      test_back_to_back();
      test_midscan_reset();
      test_random();
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end
endmodule

// File: doc/mux_scan_ctrl.md
# mux_scan_ctrl

Sequencer and capture stage wrapped around the 32-to-1 bit multiplexer. On a start request it drives the mux select through a programmable run of indices, one per clock, with wrap-around from 31 to 0. It samples the mux output for each index and reassembles the sampled bits into a 32-bit word at their original positions. It flags completion with a one-cycle `done` pulse. It sits directly upstream of the mux on `sel` and directly downstream on `y`.

## Interface
- `SEL_W`, 5, select width; the mux has 2**SEL_W inputs.
- `N`, 32, number of mux inputs; fixed as 2**SEL_W.
- `clk` input 1, single clock; all state updates on the rising edge.
- `rst_n` input 1, asynchronous active-low reset.
- `start` input 1, scan request; sampled only in IDLE.
- `first` input SEL_W, first select index of the run; sampled with `start`.
- `count` input SEL_W+1, number of indices to scan; 1..32 valid, 0 treated as 32.
- `y` input 1, mux output, combinational from `sel`.
- `sel` output SEL_W, registered mux select.
- `busy` output 1, high from the cycle after start acceptance until `done`, inclusive.
- `done` output 1, one-cycle pulse; `word` is valid while it is high and afterwards.
- `word` output N, captured bits; bit i holds `y` sampled while `sel==i`.
- `mask` output N, bit i is set if index i was scanned in the last run.

## Operation
- States: IDLE, SCAN, DONE.
- IDLE: `start`=1 latches `first` into `sel` and `count` (0→32) into `remaining`, and clears `word` and `mask` to 0. Next state is SCAN.
- SCAN, each cycle:
  - `word[sel]<=y` and `mask[sel]<=1`.
  - `sel<=sel+1` modulo 32, so 31 wraps to 0.
  - `remaining<=remaining-1`.
  - When `remaining==1` the next state is DONE, and `sel` holds its current value instead of incrementing.
- DONE: `done`=1 for exactly one cycle, then IDLE. `word`, `mask` and `sel` hold until the next accepted start.
- `start` in SCAN or DONE is ignored; there is no queueing.
- Simultaneous `start` and the DONE cycle: the start is ignored, because acceptance happens only in IDLE.
- `count`=32 with any `first` covers every index exactly once, and `mask` ends at 32'hFFFFFFFF.
- `y` is assumed stable within the cycle `sel` is driven, since the mux is purely combinational.
- Reset, asserted at any time including mid-scan, forces:
  - state IDLE;
  - `sel`=0, `word`=0, `mask`=0;
  - `busy`=0, `done`=0, `remaining`=0.
  The partial capture is discarded.

## Timing
- `start` is sampled at edge k, and `sel` equals `first` after edge k.
- Sample j is taken at edge k+1+j, for j=0..count-1.
- `done` is high in the cycle after edge k+count, so latency from start to `done` is count+1 cycles.
- The earliest next start is accepted at the edge ending the `done` cycle plus one; back-to-back throughput is count+2 cycles per run.
- All outputs are registered, and there is no combinational path from `y` to any output.

## Configuration
- `MUX_SCAN_PARITY_EN` defined: adds output `parity` (1 bit), the XOR of all bits written to `word` in the current run.
  - `parity` resets to 0, clears on start acceptance, and updates in SCAN alongside `word`.
  - `parity` is valid with `done`.
- Undefined: no `parity` port and no parity logic.

## Structure
- Package `mux_scan_pkg` holds:
  - the state enum (IDLE, SCAN, DONE);
  - `SEL_W`=5 and `N`=32;
  - `COUNT_W`=SEL_W+1.
- Sub-module `mux_scan_capture` holds the `word`/`mask` registers and, when enabled, `parity`. It takes `clr`, `we` and `idx` from the FSM and is wired to `y`.
- The FSM, `sel` counter and `remaining` counter stay in `mux_scan_ctrl`.

## Test plan
- Mux driven with I=32'd640; `start`, `first`=0, `count`=32 → `word`=32'h00000280, `mask`=32'hFFFFFFFF, `done` 33 cycles after start, `busy` high for those cycles.
- I=32'd640, `first`=30, `count`=12 → `sel` visits 30,31,0..9; `word`=32'h00000280, `mask`=32'hC00003FF.
- `count`=0, `first`=5 → 32 indices scanned, the last `sel`=4, `mask`=32'hFFFFFFFF.
- `start` pulsed again mid-scan with a different `first` → ignored; result is identical to an undisturbed run.
- `rst_n` dropped for one cycle at sample 10 of a 32-scan → all outputs 0 immediately, with no `done`. A fresh start then completes normally.
- With `MUX_SCAN_PARITY_EN`, I=32'd640 and a full scan → `parity`=0. With I=32'd641 → `parity`=1.
